alu_result_buffer: RTL
======================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: DATA_W, default 32, ALU result and branch-target width (equals the register data width).
REQ-002 Parameter: RD_W, default 5, destination register index width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  ALU stage presents a result.
REQ-006 in_ready  out  1  buffer can accept; registered, equals "not FULL".
REQ-007 in_result  in  DATA_W  ALU output; for branches bit 0 is the compare outcome.
REQ-008 in_rd  in  RD_W  destination register index.
REQ-009 in_we  in  1  result is to be written back.
REQ-010 in_is_branch  in  1  entry is a conditional branch.
REQ-011 in_target  in  DATA_W  branch target PC.
REQ-012 flush  in  1  discard all buffered and incoming entries.
REQ-013 out_valid  out  1  head entry available to writeback.
REQ-014 out_ready  in  1  writeback consumes head.
REQ-015 out_result / out_rd / out_we  out  DATA_W / RD_W / 1  head entry fields.
REQ-016 redirect_valid  out  1  one-cycle taken-branch pulse.
REQ-017 redirect_pc  out  DATA_W  taken-branch target.

Function
REQ-018 Two-entry FIFO (skid buffer); states EMPTY, ONE, FULL; state is the entry count.
REQ-019 Push when in_valid & in_ready & !flush; pop when out_valid & out_ready & !flush.
REQ-020 EMPTY: push -> ONE; no push -> EMPTY; out_valid=0.
REQ-021 ONE: push & pop -> ONE (new entry becomes head next cycle); push only -> FULL; pop only -> EMPTY.
REQ-022 FULL: in_ready=0, push impossible; pop -> ONE, second entry becomes head.
REQ-023 Latency: entry pushed in cycle N is visible on out_* in cycle N+1 when buffer was EMPTY or popped to empty in N.
REQ-024 Order strictly FIFO; no entry dropped or duplicated except by flush.
REQ-025 out_we = stored in_we & (stored in_rd != 0); x0 writes never asserted.
REQ-026 Every accepted entry is enqueued, branch or not; branches normally carry in_we=0.
REQ-027 Push with in_is_branch=1 and in_result[0]=1 -> redirect_valid=1 for exactly cycle N+1, redirect_pc = in_target registered; otherwise redirect_valid=0.
REQ-028 flush has priority over push, pop and redirect: next cycle state EMPTY, redirect_valid=0, in_ready=1.
REQ-029 redirect_pc holds its last value when redirect_valid=0.
REQ-030 out_* fields hold stable while out_valid=1 and out_ready=0.

Reset
REQ-031 rst in cycle N: in cycle N+1 state EMPTY, out_valid=0, out_result=0, out_rd=0, out_we=0, redirect_valid=0, redirect_pc=0, in_ready=1.
REQ-032 rst overrides flush, push and pop; an entry presented during rst is lost and produces no redirect.
REQ-033 rst mid-FULL discards both entries; no pop handshake completes in the rst cycle.

Configuration
REQ-034 Macro ALU_RESULT_BUFFER_FWD_EN, when defined, adds outputs fwd_valid (1), fwd_rd (RD_W), fwd_data (DATA_W).
REQ-035 With it: fwd_* reflect the newest buffered entry (tail); fwd_valid = entry present & we & rd!=0; fwd_valid=0 when EMPTY, after flush and after reset.
REQ-036 Without it: the three ports do not exist; all other behaviour identical.

Verification
REQ-037 Reset then push result 0x0000_0005, rd=3, we=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_we=1; then EMPTY.
REQ-038 out_ready=0, push 0x11 then 0x22 -> in_ready=0 after second push; release out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready returns 1.
REQ-039 Push branch in_result=1, in_target=0x0000_0100 -> redirect_valid=1 for one cycle with redirect_pc=0x100; repeat with in_result=0 -> no pulse.
REQ-040 FULL buffer plus flush together with a taken branch on input -> next cycle out_valid=0, redirect_valid=0, in_ready=1.
REQ-041 Push rd=0, we=1, result 0xDEAD_BEEF -> out_we=0; with ALU_RESULT_BUFFER_FWD_EN, push rd=7 result 0x1234 -> fwd_valid=1, fwd_rd=7, fwd_data=0x1234.

Source files
------------

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_buffer
// Description : Two-entry skid FIFO between the ALU and writeback stages.
//               Holds ALU results in order, masks x0 writes, and raises a
//               one-cycle redirect pulse when a taken conditional branch is
//               accepted. Optional macro ALU_RESULT_BUFFER_FWD_EN adds a
//               forwarding view (fwd_valid/fwd_rd/fwd_data) of the newest
//               buffered entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_is_branch,
  input  logic [DATA_W-1:0] in_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
`ifdef ALU_RESULT_BUFFER_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // State encoding is the number of buffered entries.
  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_in_ready;
  logic              r_redirect_valid;
  logic [DATA_W-1:0] r_redirect_pc;

  // Slot 0 is always the head; slot 1 holds the second entry when FULL.
  // The stored write-enable already has the x0 mask applied.
  logic [DATA_W-1:0] r_slot0_result;
  logic [RD_W-1:0]   r_slot0_rd;
  logic              r_slot0_we;
  logic [DATA_W-1:0] r_slot1_result;
  logic [RD_W-1:0]   r_slot1_rd;
  logic              r_slot1_we;

  logic              w_push;
  logic              w_pop;
  logic              w_in_we_masked;
  logic              w_taken;

  assign w_push         = in_valid & r_in_ready & ~flush;
  assign w_pop          = (r_state != c_empty) & out_ready & ~flush;
  assign w_in_we_masked = in_we & (in_rd != '0);
  assign w_taken        = w_push & in_is_branch & in_result[0];

  // Next-state computation; flush empties the buffer regardless of handshakes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_empty: if (w_push) w_state_nxt = c_one;
      c_one: begin
        if (w_push && !w_pop)      w_state_nxt = c_full;
        else if (!w_push && w_pop) w_state_nxt = c_empty;
        else                       w_state_nxt = c_one;
      end
      c_full:  if (w_pop) w_state_nxt = c_one;
      default: w_state_nxt = c_empty;
    endcase
    if (flush) w_state_nxt = c_empty;
  end

  // Control registers: occupancy, registered ready, and redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= c_empty;
      r_in_ready       <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_in_ready       <= (w_state_nxt != c_full);
      r_redirect_valid <= w_taken;
      if (w_taken) r_redirect_pc <= in_target;
    end
  end

  // Entry storage: load head when it is (or is about to be) free, else the
  // second slot; on a pop from FULL the second entry shifts into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot0_result <= '0;
      r_slot0_rd     <= '0;
      r_slot0_we     <= 1'b0;
      r_slot1_result <= '0;
      r_slot1_rd     <= '0;
      r_slot1_we     <= 1'b0;
    end else if (w_push && ((r_state == c_empty) || ((r_state == c_one) && w_pop))) begin
      r_slot0_result <= in_result;
      r_slot0_rd     <= in_rd;
      r_slot0_we     <= w_in_we_masked;
    end else if (w_push && (r_state == c_one)) begin
      r_slot1_result <= in_result;
      r_slot1_rd     <= in_rd;
      r_slot1_we     <= w_in_we_masked;
    end else if (w_pop && (r_state == c_full)) begin
      r_slot0_result <= r_slot1_result;
      r_slot0_rd     <= r_slot1_rd;
      r_slot0_we     <= r_slot1_we;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = (r_state != c_empty);
  assign out_result     = r_slot0_result;
  assign out_rd         = r_slot0_rd;
  assign out_we         = r_slot0_we;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

`ifdef ALU_RESULT_BUFFER_FWD_EN
  // Tail view: the newest entry is the head when ONE, slot 1 when FULL.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = r_slot0_rd;
    fwd_data  = r_slot0_result;
    if (r_state == c_full) begin
      fwd_valid = r_slot1_we;
      fwd_rd    = r_slot1_rd;
      fwd_data  = r_slot1_result;
    end else if (r_state == c_one) begin
      fwd_valid = r_slot0_we;
    end
  end
`endif

endmodule
`default_nettype wire
